// File: rtl/imm_decode_ctrl.sv
// Single-entry decode stage: classifies RV32 opcodes and extends immediates.
// Define IMM_DECODE_SKID_EN to add a one-entry skid buffer with a registered in_ready.
module imm_decode_ctrl #(
  parameter int ILL_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [31:0]          in_pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [31:0]          out_pc,
  output logic [31:0]          out_imm,
  output logic [2:0]           out_fmt,
  output logic                 out_illegal,
  output logic [ILL_CNT_W-1:0] ill_count,
  output logic [1:0]           state
);

  // Handshake: a transfer happens on a rising edge only when valid and ready
  // are both 1; the producer holds its payload stable while valid=1 and ready=0.

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
`ifdef IMM_DECODE_SKID_EN
  localparam logic [1:0] ST_SKID  = 2'd2;
`endif

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  // Returns {fmt, imm}; anything outside the listed opcodes is illegal.
  function automatic logic [34:0] decode(input logic [31:0] instr);
    logic [2:0]  fmt;
    logic [31:0] imm;
    fmt = FMT_ILL;
    imm = 32'h0;
    case (instr[6:0])
      7'b0110011: begin
        fmt = FMT_R;
        imm = 32'h0;
      end
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
        fmt = FMT_I;
        imm = {{20{instr[31]}}, instr[31:20]};
      end
      7'b0100011: begin
        fmt = FMT_S;
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      7'b1100011: begin
        fmt = FMT_B;
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        fmt = FMT_U;
        imm = {instr[31:12], 12'b0};
      end
      7'b1101111: begin
        fmt = FMT_J;
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: begin
        fmt = FMT_ILL;
        imm = 32'h0;
      end
    endcase
    return {fmt, imm};
  endfunction

  logic [1:0]  cur_state;
  logic [1:0]  next_state;
  logic        in_xfer;
  logic        out_xfer;
  logic        load_out;
  logic        take_skid;
  logic        load_skid;
  logic [31:0] src_instr;
  logic [31:0] src_pc;
  logic [2:0]  src_fmt;
  logic [31:0] src_imm;

  assign state     = cur_state;
  assign out_valid = (cur_state != ST_EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

`ifdef IMM_DECODE_SKID_EN
  logic        ready_r;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  // Reset gating keeps in_ready low while RESET is held, high right after.
  assign in_ready  = !RESET && ready_r;
  assign src_instr = take_skid ? skid_instr : in_instr;
  assign src_pc    = take_skid ? skid_pc    : in_pc;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ready_r    <= 1'b1;
      skid_instr <= 32'h0;
      skid_pc    <= 32'h0;
    end else begin
      ready_r <= (next_state != ST_SKID);
      if (load_skid) begin
        skid_instr <= in_instr;
        skid_pc    <= in_pc;
      end
    end
  end
`else
  assign in_ready  = !RESET && (!out_valid || out_ready);
  assign src_instr = in_instr;
  assign src_pc    = in_pc;
`endif

  assign {src_fmt, src_imm} = decode(src_instr);

  always_comb begin
    next_state = cur_state;
    load_out   = 1'b0;
    take_skid  = 1'b0;
    load_skid  = 1'b0;
    if (flush) begin
      // Flush wins: held entries and any same-cycle input are dropped.
      next_state = ST_EMPTY;
    end else begin
      case (cur_state)
        ST_EMPTY: begin
          if (in_xfer) begin
            next_state = ST_FULL;
            load_out   = 1'b1;
          end
        end
        ST_FULL: begin
          if (in_xfer && out_xfer) begin
            next_state = ST_FULL;
            load_out   = 1'b1;
          end else if (out_xfer) begin
            next_state = ST_EMPTY;
`ifdef IMM_DECODE_SKID_EN
          end else if (in_xfer) begin
            next_state = ST_SKID;
            load_skid  = 1'b1;
`endif
          end
        end
`ifdef IMM_DECODE_SKID_EN
        ST_SKID: begin
          // in_ready is low here, so only the buffered entry can move up.
          if (out_xfer) begin
            next_state = ST_FULL;
            load_out   = 1'b1;
            take_skid  = 1'b1;
          end
        end
`endif
        default: next_state = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cur_state <= ST_EMPTY;
    end else begin
      cur_state <= next_state;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_instr   <= 32'h0;
      out_pc      <= 32'h0;
      out_imm     <= 32'h0;
      out_fmt     <= 3'd0;
      out_illegal <= 1'b0;
    end else if (load_out) begin
      out_instr   <= src_instr;
      out_pc      <= src_pc;
      out_imm     <= src_imm;
      out_fmt     <= src_fmt;
      out_illegal <= (src_fmt == FMT_ILL);
    end
  end

  // An entry leaving in a flush cycle is discarded, so it is not counted.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ill_count <= '0;
    end else if (!flush && out_xfer && out_illegal && (ill_count != '1)) begin
      ill_count <= ill_count + ILL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Directed bench for imm_decode_ctrl: driver pushes expected entries, monitor pops and compares.
module tb_imm_decode_ctrl;
  localparam int W = 100;
`ifdef IMM_DECODE_SKID_EN
  localparam int STALL_ACC = 2;
`else
  localparam int STALL_ACC = 1;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'h0;
  logic [31:0] in_pc = 32'h0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_illegal;
  logic [7:0]  ill_count;
  logic [1:0]  state;

  logic        sat_in_ready;
  logic        sat_out_valid;
  logic [31:0] sat_out_instr;
  logic [31:0] sat_out_pc;
  logic [31:0] sat_out_imm;
  logic [2:0]  sat_out_fmt;
  logic        sat_out_illegal;
  logic [1:0]  sat_ill_count;
  logic [1:0]  sat_state;

  imm_decode_ctrl #(.ILL_CNT_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_illegal(out_illegal), .ill_count(ill_count), .state(state)
  );

  // Narrow-counter copy fed the same stimulus, used only for saturation.
  imm_decode_ctrl #(.ILL_CNT_W(2)) dut_sat (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(sat_out_valid),
    .out_ready(out_ready), .out_instr(sat_out_instr), .out_pc(sat_out_pc),
    .out_imm(sat_out_imm), .out_fmt(sat_out_fmt), .out_illegal(sat_out_illegal),
    .ill_count(sat_ill_count), .state(sat_state)
  );

  always #5 CLK = ~CLK;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0] pc_ctr = 32'h0000_1000;

  logic [31:0] v_instr [0:10] = '{32'hFFF00093, 32'hFE000EE3, 32'h123452B7, 32'h00512423,
                                  32'h0080006F, 32'h002081B3, 32'hFFFFF297, 32'h80012083,
                                  32'h00000073, 32'hFE112E23, 32'hFFDFF06F};
  logic [2:0]  v_fmt [0:10]   = '{3'd1, 3'd3, 3'd4, 3'd2, 3'd5, 3'd0, 3'd4, 3'd1, 3'd1, 3'd2, 3'd5};
  logic [31:0] v_imm [0:10]   = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'h00000008,
                                  32'h00000008, 32'h00000000, 32'hFFFFF000, 32'hFFFFF800,
                                  32'h00000000, 32'hFFFFFFFC, 32'hFFFFFFFC};
  logic [31:0] s_instr [0:3]  = '{32'h00100093, 32'h00200093, 32'h00300093, 32'h00400093};

  function automatic logic [W-1:0] mk(input logic [31:0] instr, input logic [31:0] pc,
                                      input logic [2:0] fmt, input logic [31:0] imm);
    return {instr, pc, imm, fmt, fmt == 3'd7};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every presented entry must match the oldest expected entry.
  always @(negedge CLK) begin
    if (!RESET && out_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got instr %h expected no entry", out_instr);
      end else begin
        if ({out_instr, out_pc, out_imm, out_fmt, out_illegal} !== exp_q[0]) begin
          n_fail++;
          $display("FAIL out_entry: got %h expected %h",
                   {out_instr, out_pc, out_imm, out_fmt, out_illegal}, exp_q[0]);
        end
        if (out_ready && !flush) void'(exp_q.pop_front());
      end
    end
    if (!RESET && flush) exp_q.delete();
  end

  task automatic send(input logic [31:0] instr, input logic [2:0] fmt,
                      input logic [31:0] imm, input logic fl);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc_ctr;
    flush    = fl;
    @(negedge CLK);
    while (!in_ready && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 for %h", instr);
    end else if (!fl) begin
      exp_q.push_back(mk(instr, pc_ctr, fmt, imm));
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    pc_ctr   = pc_ctr + 32'd4;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge CLK);
      #2;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1);
  end

  initial begin
    int idx;
    // Reset values, before any clock edge.
    #1 RESET = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_ill_count", 32'(ill_count), 32'd0);
    check("rst_out_fields", {out_instr[15:0], out_pc[15:0]} | out_imm | 32'(out_fmt) | 32'(out_illegal), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Format and immediate vectors, back to back with out_ready=1.
    send(v_instr[0], v_fmt[0], v_imm[0], 1'b0);
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_fmt", 32'(out_fmt), 32'd1);
    check("addi_imm", out_imm, 32'hFFFFFFFF);
    for (int i = 1; i < 11; i++) send(v_instr[i], v_fmt[i], v_imm[i], 1'b0);
    wait_drain("drain_vectors");
    check("ill_count_none", 32'(ill_count), 32'd0);

    // Illegal words: three zeros, then two other illegal encodings.
    repeat (3) send(32'h00000000, 3'd7, 32'h0, 1'b0);
    wait_drain("drain_ill3");
    check("ill_count_3", 32'(ill_count), 32'd3);
    send(32'h0000007F, 3'd7, 32'h0, 1'b0);
    send(32'h00000012, 3'd7, 32'h0, 1'b0);
    wait_drain("drain_ill5");
    check("ill_count_5", 32'(ill_count), 32'd5);
    check("ill_count_sat", 32'(sat_ill_count), 32'd3);

    // Stall: out_ready low for 4 cycles with input continuously offered.
    out_ready = 1'b0;
    idx       = 0;
    in_valid  = 1'b1;
    in_instr  = s_instr[0];
    in_pc     = pc_ctr;
    for (int c = 0; c < 24; c++) begin
      if (c == 4) begin
        check("stall_accepts", 32'(idx), 32'(STALL_ACC));
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_state", 32'(state), 32'(STALL_ACC));
        out_ready = 1'b1;
      end
      if (c >= 4 && idx >= 4) break;
      @(negedge CLK);
      if (in_ready && idx < 4) begin
        exp_q.push_back(mk(s_instr[idx], pc_ctr, 3'd1, 32'(idx + 1)));
        idx++;
        pc_ctr = pc_ctr + 32'd4;
      end
      @(posedge CLK);
      #1;
      if (idx < 4) begin
        in_instr = s_instr[idx];
        in_pc    = pc_ctr;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("stall_all_sent", 32'(idx), 32'd4);
    wait_drain("drain_stall");

    // Flush with an input transfer while FULL holding an illegal entry.
    out_ready = 1'b0;
    send(32'h00000000, 3'd7, 32'h0, 1'b0);
    check("pre_flush_state", 32'(state), 32'd1);
    out_ready = 1'b1;
    send(v_instr[2], v_fmt[2], v_imm[2], 1'b1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_state", 32'(state), 32'd0);
    check("flush_ill_count", 32'(ill_count), 32'd5);
    @(posedge CLK);
    #2;
    check("flush_stays_empty", 32'(out_valid), 32'd0);

    // Asynchronous reset pulse in the middle of a stall.
    out_ready = 1'b0;
    send(v_instr[1], v_fmt[1], v_imm[1], 1'b0);
    #2;
    RESET = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_ill_count", 32'(ill_count), 32'd0);
    check("midrst_out_instr", out_instr, 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge CLK);
    #1 RESET = 1'b0;
    #1;
    check("midrst_in_ready_after", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    send(v_instr[4], v_fmt[4], v_imm[4], 1'b0);
    wait_drain("drain_final");
    check("final_ill_count", 32'(ill_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
